inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Parameterised FIFO between instruction fetch and the decode/issue stage. It buffers fetched instruction words with their PCs.
- Presents the oldest entry to decode, which captures it into its pipeline registers (load/clr style).
- Decouples fetch stalls (cache misses) from decode stalls (full reservation stations / ROB).
- Supports a synchronous flush for branch mispredict recovery.

Parameters:
- width, 16, instruction word width in bits
- pc_width, 16, PC width in bits
- depth, 8, number of entries; must be a power of 2 and ≥ 2
- ptr_width, $clog2(depth), index width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all entries; highest priority
- enq_valid  input  1  fetch presents a valid instruction
- enq_ready  output  1  queue can accept (= not full)
- enq_inst  input  width  instruction word
- enq_pc  input  pc_width  PC of instruction
- deq_valid  output  1  head entry valid (= not empty)
- deq_ready  input  1  decode consumes head this cycle
- deq_inst  output  width  head instruction word
- deq_pc  output  pc_width  head PC
- count  output  ptr_width+1  occupancy, 0..depth

Behaviour:
- Storage: depth-entry array of {pc, inst}. Read pointer and write pointer are each ptr_width+1 bits; the MSB is the wrap bit.
  - empty = (rd_ptr == wr_ptr)
  - full = index bits equal and wrap bits differ
- Reset (rst_n=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0. Therefore enq_ready=1 and deq_valid=0. deq_inst/deq_pc are don't-care while deq_valid=0. Array contents are not reset.
- enq fires when enq_valid & enq_ready at the clock edge: write the entry at wr_ptr, then wr_ptr+1 (modulo 2*depth, natural wrap).
- deq fires when deq_valid & deq_ready: rd_ptr+1.
- enq_ready = ~full. It does not depend on deq_ready (no full-pass-through), so there is no combinational ready path.
- deq_valid = ~empty. deq_inst/deq_pc are combinational reads of the array at rd_ptr.
- Latency: an entry enqueued at edge N is visible on deq_* after edge N (earliest consume at edge N+1). There is no empty-bypass.
- Simultaneous enq and deq (both fire): both pointers advance and count is unchanged.
  - With one entry, the head is the old entry this cycle; the new entry becomes head next cycle.
- count: +1 on enq only, −1 on deq only, unchanged on both/neither. It always equals wr_ptr − rd_ptr.
- flush=1 at an edge: rd_ptr=wr_ptr=0, count=0. Any enq/deq in that cycle is discarded (flush wins). The outputs behave as after reset from the next cycle.
- Protocol rules:
  - enq_valid with enq_ready=0 writes nothing and leaves state unchanged; fetch must hold its data.
  - deq_ready with deq_valid=0 is ignored.
  - Producer may deassert enq_valid at any time (no stickiness required).
- Reset asserted mid-operation clears the pointers immediately (asynchronously), regardless of clk.
- Ordering is strict FIFO; no entry is ever duplicated or dropped except by flush or reset.

Test Plan:
1. Reset then enq 0x1234/pc 0x0040 → next cycle deq_valid=1, deq_inst=0x1234, deq_pc=0x0040, count=1; deq with deq_ready=1 → deq_valid=0, count=0.
2. Fill: 8 enqueues of 0x1000..0x1007 with deq_ready=0 → enq_ready=0 and count=8 after the 8th. A 9th enq_valid (0xDEAD) is dropped. Drain yields 0x1000..0x1007 in order, then deq_valid=0.
3. Continuous stream: enq and deq every cycle for 20 cycles starting from 1 entry → count stays 1, pointers wrap past depth twice, output order matches input order, no bubbles.
4. Full plus simultaneous deq: at count=8 assert deq_ready=1 and enq_valid=1 → deq fires, enq does not (enq_ready=0), count=7. Next cycle the enq is accepted, count=8.
5. Flush with count=5 and simultaneous enq/deq → next cycle count=0, deq_valid=0, enq_ready=1. A subsequent enq 0x0ABC is the next entry dequeued.
6. Async reset: drop rst_n mid-cycle (between edges) with count=3 → deq_valid=0 and count=0 immediately, before the next clk edge. Normal operation resumes after rst_n rises.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue: FIFO of {pc, inst} between fetch and decode/issue.
// Wrap-bit pointers distinguish full from empty; flush clears synchronously.
module inst_queue #(
  parameter int unsigned  width     = 16,
  parameter int unsigned  pc_width  = 16,
  parameter int unsigned  depth     = 8,
  localparam int unsigned ptr_width = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [width-1:0]     enq_inst,
  input  logic [pc_width-1:0]  enq_pc,
  output logic                 deq_valid,
  input  logic                 deq_ready,
  output logic [width-1:0]     deq_inst,
  output logic [pc_width-1:0]  deq_pc,
  output logic [ptr_width:0]   count
);

  localparam int unsigned CntW = ptr_width + 1;

  typedef struct packed {
    logic [pc_width-1:0] pc;
    logic [width-1:0]    inst;
  } entry_t;

  entry_t               mem_q [depth];
  logic [CntW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ptr_width-1:0] rd_idx, wr_idx;
  logic                 full, empty;
  logic                 enq_fire, deq_fire;
  entry_t               head;

  assign rd_idx = rd_ptr_q[ptr_width-1:0];
  assign wr_idx = wr_ptr_q[ptr_width-1:0];

  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign full  = (rd_idx == wr_idx) && (rd_ptr_q[ptr_width] != wr_ptr_q[ptr_width]);
  assign empty = (rd_ptr_q == wr_ptr_q);

  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign enq_fire  = enq_valid & ~full;
  assign deq_fire  = deq_ready & ~empty;

  assign head     = mem_q[rd_idx];
  assign deq_inst = head.inst;
  assign deq_pc   = head.pc;
  assign count    = wr_ptr_q - rd_ptr_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + CntW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is deliberately left unreset; entries are only read when valid.
  always_ff @(posedge clk) begin
    if (enq_fire && !flush) begin
      mem_q[wr_idx] <= entry_t'({enq_pc, enq_inst});
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed stimulus, expected entries queued on enqueue
// and checked by an independent monitor when decode consumes the head.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [15:0] enq_inst;
  logic [15:0] enq_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [15:0] deq_inst;
  logic [15:0] deq_pc;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  int mc    = 0;
  logic [31:0] exp_q [$];

  inst_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_inst  (enq_inst),
    .enq_pc    (enq_pc),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_inst  (deq_inst),
    .deq_pc    (deq_pc),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: decode consumes the head on the coming edge unless flush discards it.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && deq_valid === 1'b1 && deq_ready === 1'b1 && flush === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL deq_unexpected: got inst 0x%0h expected no entry", deq_inst);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("deq_pc", 32'(deq_pc), 32'(e[31:16]));
        chk("deq_inst", 32'(deq_inst), 32'(e[15:0]));
      end
    end
  end

  // One clock of stimulus; model updated after the edge, then status checked.
  task automatic step(input logic ev, input logic [15:0] inst, input logic [15:0] pc,
                      input logic dr, input logic fl);
    bit ef, df;
    enq_valid = ev;
    enq_inst  = inst;
    enq_pc    = pc;
    deq_ready = dr;
    flush     = fl;
    ef = ev && (mc < 8);
    df = dr && (mc > 0);
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      mc = 0;
    end else begin
      if (ef) begin
        exp_q.push_back({pc, inst});
        mc++;
      end
      if (df) mc--;
    end
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    chk("count", 32'(count), 32'(mc));
    chk("deq_valid", 32'(deq_valid), 32'(mc > 0));
    chk("enq_ready", 32'(enq_ready), 32'(mc < 8));
    if (mc > 0 && exp_q.size() > 0) begin
      logic [31:0] h;
      h = exp_q[0];
      chk("head_inst", 32'(deq_inst), 32'(h[15:0]));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_inst  = '0;
    enq_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    rst_n = 1'b1;

    // 1: single entry round trip
    step(1'b1, 16'h1234, 16'h0040, 1'b0, 1'b0);
    chk("t1_pc", 32'(deq_pc), 32'h0040);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // 2: fill, overflow attempt dropped, drain in order
    for (int i = 0; i < 8; i++) step(1'b1, 16'h1000 + 16'(i), 16'h0100 + 16'(2 * i), 1'b0, 1'b0);
    chk("t2_full_ready", 32'(enq_ready), 32'd0);
    step(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("t2_empty", 32'(deq_valid), 32'd0);

    // 3: continuous stream holding one entry
    step(1'b1, 16'h2000, 16'h0200, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) step(1'b1, 16'h2000 + 16'(i), 16'h0200 + 16'(i), 1'b1, 1'b0);
    chk("t3_count", 32'(count), 32'd1);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // 4: full with simultaneous enq/deq, only deq fires
    for (int i = 0; i < 8; i++) step(1'b1, 16'h3000 + 16'(i), 16'h0300 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'h3100, 16'h0310, 1'b1, 1'b0);
    chk("t4_count7", 32'(count), 32'd7);
    step(1'b1, 16'h3100, 16'h0310, 1'b0, 1'b0);
    chk("t4_count8", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // 5: flush beats simultaneous enq/deq
    for (int i = 0; i < 5; i++) step(1'b1, 16'h4000 + 16'(i), 16'h0400 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'h4FFF, 16'h04FF, 1'b1, 1'b1);
    chk("t5_count", 32'(count), 32'd0);
    step(1'b1, 16'h0ABC, 16'h0ABC, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // 6: asynchronous reset between edges
    for (int i = 0; i < 3; i++) step(1'b1, 16'h5000 + 16'(i), 16'h0500 + 16'(i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_valid", 32'(deq_valid), 32'd0);
    exp_q.delete();
    mc = 0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h6001, 16'h0601, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    chk("end_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
